update_knn9_topk_dist: RTL and testbench



---
 rtl/update_knn9_pkg.sv | 18 +
 rtl/update_knn9_align_pipe.sv | 41 ++++
 rtl/update_knn9_topk_dist.sv | 156 +++++++++++++++
 tb/tb_update_knn9_topk_dist.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/update_knn9_pkg.sv
// Shared definitions for the update_knn9 top-K distance stage.
package update_knn9_pkg;

   localparam int DIST_WIDTH_DEF  = 32;
   localparam int LABEL_WIDTH_DEF = 4;

   // Wide all-ones pattern; users cast it down to their own distance width
   // (valid for distance widths up to 64 bits).
   localparam logic [63:0] DIST_INIT = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/update_knn9_align_pipe.sv
// Valid/label delay line that mirrors the multiplier register stages, so the
// last stage lines up with the product emerging on the multiplier output.
module update_knn9_align_pipe #(
   parameter int LABEL_WIDTH = 4,
   parameter int DEPTH       = 2
) (
   input  logic                   clk,
   input  logic                   i_clear_n,
   input  logic                   i_ce,
   input  logic                   i_vld,
   input  logic [LABEL_WIDTH-1:0] i_label,
   output logic                   o_vld,
   output logic [LABEL_WIDTH-1:0] o_label,
   output logic                   o_anyVld
);

   logic [DEPTH-1:0]       r_vld;
   logic [LABEL_WIDTH-1:0] r_label [DEPTH];

   // Shift {vld, label} one stage per enabled cycle; clear empties every stage.
   always_ff @(posedge clk) begin
      if (!i_clear_n) begin
         r_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_label[i] <= '0;
         end
      end else if (i_ce) begin
         r_vld[0]   <= i_vld;
         r_label[0] <= i_label;
         for (int i = 1; i < DEPTH; i++) begin
            r_vld[i]   <= r_vld[i-1];
            r_label[i] <= r_label[i-1];
         end
      end
   end

   assign o_vld    = r_vld[DEPTH-1];
   assign o_label  = r_label[DEPTH-1];
   assign o_anyVld = |r_vld;

endmodule

// File: rtl/update_knn9_topk_dist.sv
// Keeps the K smallest multiplier products of a query, with their labels,
// and pulses done once every sample of the query has been considered.
module update_knn9_topk_dist
   import update_knn9_pkg::*;
#(
   parameter int DIST_WIDTH  = DIST_WIDTH_DEF,
   parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
   parameter int K           = 3,
   parameter int NUM_SAMPLES = 1800,
   parameter int MUL_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     ce,
   input  logic                     start,
   input  logic                     in_vld,
   input  logic [LABEL_WIDTH-1:0]   in_label,
   input  logic [DIST_WIDTH-1:0]    din,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              sample_cnt,
   output logic [K*DIST_WIDTH-1:0]  knn_dist,
   output logic [K*LABEL_WIDTH-1:0] knn_label
);

   localparam logic [DIST_WIDTH-1:0] W_DIST_INIT = DIST_WIDTH'(DIST_INIT);
   localparam logic [15:0]           LAST_COUNT  = 16'(NUM_SAMPLES - 1);

   state_t                 r_state;
   logic                   r_busy;
   logic                   r_done;
   logic [15:0]            r_cnt;
   logic [DIST_WIDTH-1:0]  r_dist  [K];
   logic [LABEL_WIDTH-1:0] r_label [K];

   logic [DIST_WIDTH-1:0]  w_nextDist  [K];
   logic [LABEL_WIDTH-1:0] w_nextLabel [K];

   logic                   w_startAccept;
   logic                   w_pipeClearN;
   logic                   w_loadVld;
   logic                   w_pipeVld;
   logic [LABEL_WIDTH-1:0] w_pipeLabel;
   logic                   w_pipeAny;
   logic                   w_insert;

   // A start only counts while idle; it also flushes anything left in flight.
   assign w_startAccept = start && (r_state == IDLE);
   assign w_pipeClearN  = reset_n && !w_startAccept;
   assign w_loadVld     = in_vld && (r_state == RUN);
   assign w_insert      = ce && w_pipeVld;

   update_knn9_align_pipe #(
      .LABEL_WIDTH (LABEL_WIDTH),
      .DEPTH       (MUL_LATENCY)
   ) u_alignPipe (
      .clk       (clk),
      .i_clear_n (w_pipeClearN),
      .i_ce      (ce),
      .i_vld     (w_loadVld),
      .i_label   (in_label),
      .o_vld     (w_pipeVld),
      .o_label   (w_pipeLabel),
      .o_anyVld  (w_pipeAny)
   );

   // Sorted insertion: each slot either shifts down from above, takes the new
   // product, or holds; ties leave the older entry at the lower index.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         w_nextDist[i]  = r_dist[i];
         w_nextLabel[i] = r_label[i];
      end
      if (din < r_dist[0]) begin
         w_nextDist[0]  = din;
         w_nextLabel[0] = w_pipeLabel;
      end
      for (int i = 1; i < K; i++) begin
         if (din < r_dist[i-1]) begin
            w_nextDist[i]  = r_dist[i-1];
            w_nextLabel[i] = r_label[i-1];
         end else if (din < r_dist[i]) begin
            w_nextDist[i]  = din;
            w_nextLabel[i] = w_pipeLabel;
         end
      end
   end

   // Result table: cleared by reset or an accepted start, updated per aligned product.
   always_ff @(posedge clk) begin
      if (!reset_n || w_startAccept) begin
         for (int i = 0; i < K; i++) begin
            r_dist[i]  <= W_DIST_INIT;
            r_label[i] <= '0;
         end
      end else if (w_insert) begin
         for (int i = 0; i < K; i++) begin
            r_dist[i]  <= w_nextDist[i];
            r_label[i] <= w_nextLabel[i];
         end
      end
   end

   // Query sequencer with registered busy/done and the issued-sample counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (ce && in_vld) begin
                  r_cnt <= r_cnt + 16'd1;
                  if (r_cnt == LAST_COUNT) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (ce && !w_pipeAny) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign sample_cnt = r_cnt;

   for (genvar g = 0; g < K; g++) begin : g_pack
      assign knn_dist[g*DIST_WIDTH +: DIST_WIDTH]    = r_dist[g];
      assign knn_label[g*LABEL_WIDTH +: LABEL_WIDTH] = r_label[g];
   end

endmodule

// File: tb/tb_update_knn9_topk_dist.sv
// Directed bench for update_knn9_topk_dist: three instances with different
// sample counts share stimulus, each with its own start strobe.
module tb_update_knn9_topk_dist;

   localparam int DW = 32;
   localparam int LW = 4;
   localparam int KK = 3;

   localparam logic [KK*DW-1:0] ALL_ONES_DIST = {KK*DW{1'b1}};
   localparam logic [KK*DW-1:0] EXP1_DIST     = {32'd20, 32'd20, 32'd10};
   localparam logic [KK*LW-1:0] EXP1_LABEL    = {4'd5, 4'd2, 4'd4};

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce = 1'b1;
   logic          start6 = 1'b0;
   logic          start4 = 1'b0;
   logic          start2 = 1'b0;
   logic          in_vld = 1'b0;
   logic [LW-1:0] in_label = '0;
   logic [DW-1:0] mulIn = '0;
   logic [DW-1:0] mulS1 = '0;
   logic [DW-1:0] mulS2 = '0;

   logic             busy6, done6, busy4, done4, busy2, done2;
   logic [15:0]      cnt6, cnt4, cnt2;
   logic [KK*DW-1:0] dist6, dist4, dist2;
   logic [KK*LW-1:0] label6, label4, label2;

   int errors = 0;
   int checks = 0;
   int cycles;

   int unsigned t1Prod [6] = '{50, 20, 70, 10, 20, 90};

   // Free-running clock.
   always #5 clk = ~clk;

   // Stand-in for the ce-gated two-stage multiplier: the product presented at
   // issue time appears on din two enabled clocks later.
   always @(posedge clk) begin
      if (ce) begin
         mulS1 <= mulIn;
         mulS2 <= mulS1;
      end
   end

   update_knn9_topk_dist #(.DIST_WIDTH(DW), .LABEL_WIDTH(LW), .K(KK),
                           .NUM_SAMPLES(6), .MUL_LATENCY(2)) dut6 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .start(start6), .in_vld(in_vld),
      .in_label(in_label), .din(mulS2), .busy(busy6), .done(done6),
      .sample_cnt(cnt6), .knn_dist(dist6), .knn_label(label6));

   update_knn9_topk_dist #(.DIST_WIDTH(DW), .LABEL_WIDTH(LW), .K(KK),
                           .NUM_SAMPLES(4), .MUL_LATENCY(2)) dut4 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .start(start4), .in_vld(in_vld),
      .in_label(in_label), .din(mulS2), .busy(busy4), .done(done4),
      .sample_cnt(cnt4), .knn_dist(dist4), .knn_label(label4));

   update_knn9_topk_dist #(.DIST_WIDTH(DW), .LABEL_WIDTH(LW), .K(KK),
                           .NUM_SAMPLES(2), .MUL_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .start(start2), .in_vld(in_vld),
      .in_label(in_label), .din(mulS2), .busy(busy2), .done(done2),
      .sample_cnt(cnt2), .knn_dist(dist2), .knn_label(label2));

   // Drive one cycle of inputs from a negedge and return on the next negedge.
   task automatic applyStimulus(input logic vld, input logic [LW-1:0] lbl,
                                input logic [DW-1:0] prod, input logic ceVal);
      ce       = ceVal;
      in_vld   = vld;
      in_label = lbl;
      mulIn    = prod;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic doneOf(input int which);
      case (which)
         6:       return done6;
         4:       return done4;
         default: return done2;
      endcase
   endfunction

   // Idle cycles until the selected instance pulses done; -1 if the budget runs out.
   task automatic waitDone(input int which, input int budget, output int seen);
      seen = -1;
      for (int c = 1; c <= budget; c++) begin
         applyStimulus(1'b0, '0, '0, 1'b1);
         if (doneOf(which)) begin
            seen = c;
            break;
         end
      end
   endtask

   // Bound on total run time in case something never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of all scenarios.
   initial begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("rst_busy",  busy6, 0);
      checkOutput("rst_done",  done6, 0);
      checkOutput("rst_cnt",   cnt6, 0);
      checkOutput("rst_dist",  dist6, ALL_ONES_DIST);
      checkOutput("rst_label", label6, 0);
      reset_n = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);

      // Basic query, with a start pulse mid-run that must be ignored.
      start6 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);
      start6 = 1'b0;
      checkOutput("t1_busy", busy6, 1);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) start6 = 1'b1;
         applyStimulus(1'b1, 4'(i + 1), t1Prod[i], 1'b1);
         start6 = 1'b0;
      end
      checkOutput("t1_cnt", cnt6, 6);
      waitDone(6, 20, cycles);
      checkOutput("t1_done_latency", cycles, 3);
      checkOutput("t1_dist",  dist6, EXP1_DIST);
      checkOutput("t1_label", label6, EXP1_LABEL);
      checkOutput("t1_busy_done", busy6, 0);
      applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("t1_done_pulse", done6, 0);

      // Samples offered while idle must be ignored.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd9, 32'd1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("t6_cnt",   cnt6, 6);
      checkOutput("t6_dist",  dist6, EXP1_DIST);
      checkOutput("t6_label", label6, EXP1_LABEL);
      checkOutput("t6_busy",  busy6, 0);

      // Same query with ce stalls; stalled cycles carry a bogus small product.
      start6 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);
      start6 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 4'(i + 1), t1Prod[i], 1'b1);
         if (i % 2 == 1) begin
            for (int s = 0; s < 3; s++) applyStimulus(1'b1, 4'd15, 32'd1, 1'b0);
            checkOutput($sformatf("t3_cnt_%0d", i), cnt6, i + 1);
         end
      end
      waitDone(6, 20, cycles);
      checkOutput("t3_done_seen", cycles > 0, 1);
      checkOutput("t3_dist",  dist6, EXP1_DIST);
      checkOutput("t3_label", label6, EXP1_LABEL);

      // Reset in the middle of a query, then a clean full query.
      start6 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);
      start6 = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i + 1), 32'(i + 1), 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b1);
      reset_n = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b1);
      reset_n = 1'b1;
      checkOutput("t5_busy",  busy6, 0);
      checkOutput("t5_dist",  dist6, ALL_ONES_DIST);
      checkOutput("t5_label", label6, 0);
      checkOutput("t5_cnt",   cnt6, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1);
      checkOutput("t5_dist_quiet", dist6, ALL_ONES_DIST);
      start6 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);
      start6 = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i + 1), t1Prod[i], 1'b1);
      waitDone(6, 20, cycles);
      checkOutput("t5_done_latency", cycles, 3);
      checkOutput("t5_dist",  dist6, EXP1_DIST);
      checkOutput("t5_label", label6, EXP1_LABEL);

      // Equal distances keep arrival order; the fourth tie is dropped.
      start4 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);
      start4 = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 1), 32'd5, 1'b1);
      waitDone(4, 20, cycles);
      checkOutput("t2_done_latency", cycles, 3);
      checkOutput("t2_cnt",   cnt4, 4);
      checkOutput("t2_dist",  dist4, {32'd5, 32'd5, 32'd5});
      checkOutput("t2_label", label4, {4'd3, 4'd2, 4'd1});

      // Fewer samples than slots leaves the tail at its reset value.
      start2 = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1);
      start2 = 1'b0;
      applyStimulus(1'b1, 4'd1, 32'd40, 1'b1);
      applyStimulus(1'b1, 4'd2, 32'd30, 1'b1);
      waitDone(2, 20, cycles);
      checkOutput("t4_done_seen", cycles > 0, 1);
      checkOutput("t4_dist",  dist2, {32'hFFFF_FFFF, 32'd40, 32'd30});
      checkOutput("t4_label", label2, {4'd0, 4'd1, 4'd2});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
